memory_bank: RTL and testbench
==============================

// Module: memory_bank
// PURPOSE
//  Parametrised single-port RAM bank: successor to the basic 8-bit memory model.
//  Adds byte-lane write strobes, a valid/ready request handshake and selectable read latency (1 or 2).
//  Adds a self-clearing init sequencer that fills every word with INIT_VAL after reset.
//  Sits between a bus/command master and storage, as a testbench DUT or as an SoC scratchpad.
// PARAMETERS
//  ADDR_WIDTH    2      address bits; DEPTH = 2**ADDR_WIDTH words
//  DATA_WIDTH    8      word width; must be a multiple of 8
//  READ_LATENCY  1      cycles from accepted read to rvalid; legal values 1 or 2
//  INIT_VAL      'hFF   per-byte fill value written during init (replicated over all byte lanes)
// PORTS
//  clk        in   1             clock; all logic on posedge
//  reset      in   1             synchronous, active-high reset
//  req_valid  in   1             request present
//  req_ready  out  1             bank can accept; request accepted when req_valid && req_ready
//  req_write  in   1             1 = write, 0 = read
//  addr       in   ADDR_WIDTH    word address
//  wdata      in   DATA_WIDTH    write data
//  wstrb      in   DATA_WIDTH/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
//  rvalid     out  1             rdata valid for exactly this cycle
//  rdata      out  DATA_WIDTH    read data
//  init_done  out  1             high once the init fill has completed
// BEHAVIOUR
//  Reset (sampled on a clk edge): req_ready=0, rvalid=0, rdata=0, init_done=0.
//   Pending reads are discarded, the read pipeline is flushed, and the FSM goes to INIT with init_cnt=0.
//  FSM has two states, INIT and RUN.
//  INIT: each cycle writes {DATA_WIDTH/8{INIT_VAL[7:0]}} to mem[init_cnt], then increments init_cnt.
//   After writing init_cnt==DEPTH-1 -> RUN, init_done=1. Fill takes exactly DEPTH cycles.
//   req_ready=0 throughout INIT.
//  RUN: req_ready=1 every cycle; no backpressure on reads; one request per cycle.
//  Write on accept: for each lane i with wstrb[i]=1, mem[addr] byte i <= wdata byte i.
//   Other lanes keep their value. wstrb==0 is a legal no-op. No response is produced.
//  Read on accept, READ_LATENCY=1: rdata/rvalid update on the next edge.
//   READ_LATENCY=2: adds one output register stage; fully pipelined, one read per cycle.
//   rvalid follows the accept stream exactly: back-to-back reads give back-to-back rvalid.
//  rdata holds its last value when rvalid=0.
//  Write then read of the same address on consecutive cycles returns the new data (no hazard).
//  Address wrap: addr is exactly ADDR_WIDTH bits, so every address is in range; no error path.
//  Reset in mid-fill or mid-read: restarts INIT from 0, in-flight rvalid dropped and never emitted.
//  req_* inputs are ignored (not accepted) while req_ready=0; the master must hold them until accepted.
// STRUCTURE
//  memory_bank_pkg: typedef enum logic {ST_INIT, ST_RUN} bank_state_t.
//   Also holds localparam-style helper function depth(aw) = 2**aw.
//  Sub-module memory_bank_array: the storage plus byte-strobe write and registered read port.
//   Ports: clk, we, addr, wdata, wstrb, re, rdata.
//  Top holds: FSM, init counter, init/request write mux, rvalid pipeline, optional 2nd rdata stage.
// TESTING (ADDR_WIDTH=2, DATA_WIDTH=16, INIT_VAL='hFF unless noted)
//  1 Reset 1 cycle, then wait: init_done rises exactly 4 cycles after reset low.
//    Reads of addr 0..3 -> rdata=16'hFFFF each, rvalid 1 cycle after accept.
//  2 Write addr 1 wdata 16'hA5C3 wstrb 2'b01, then read addr 1 -> 16'hFFC3.
//    Then write wstrb 2'b10 wdata 16'h1200 -> read gives 16'h12C3.
//  3 Back-to-back reads addr 0,1,2,3 with READ_LATENCY=2 after writing 16'h0000..16'h0003:
//    rvalid high 4 consecutive cycles starting 2 cycles after first accept, data 0,1,2,3.
//  4 Write addr 3 16'hBEEF (wstrb 2'b11) immediately followed by read addr 3 -> 16'hBEEF.
//  5 Assert reset during INIT at init_cnt=2 and again with a read in flight.
//    No rvalid follows the reset; init restarts, all words 16'hFFFF afterwards.
//  6 req_valid held during INIT: no write occurs.
//    Request accepted on the first RUN cycle only; memory reflects a single write.

Source files
------------

// File: rtl/memory_bank_pkg.sv
// Shared types and helpers for the memory_bank RAM and its storage array.
package memory_bank_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bank_state_t;

  function automatic int depth(input int aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/memory_bank_array.sv
// Word storage with per-byte-lane write enables and a registered read port.
module memory_bank_array
  import memory_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      re,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write never coincide: the bank is single-port and the top issues one or the other.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_bank.sv
// Single-port RAM bank: post-reset fill sequencer, valid/ready requests,
// byte-strobed writes and a 1- or 2-cycle read pipeline.
module memory_bank
  import memory_bank_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 2,
  parameter int          DATA_WIDTH   = 8,
  parameter int          READ_LATENCY = 1,
  parameter logic [7:0]  INIT_VAL     = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      init_done
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int NB    = DATA_WIDTH / 8;

  // Handshake: a request transfers on a clk edge where req_valid && req_ready;
  // the master holds req_* stable until then. Reads never see backpressure.

  bank_state_t           state;
  bank_state_t           state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_we;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [NB-1:0]         arr_wstrb;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  rv1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Gating with reset keeps a request from landing on the very edge that resets the bank.
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    init_we   = 1'b0;
    case (state)
      ST_INIT: init_we = !reset;
      ST_RUN: begin
        req_ready = !reset;
        init_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                 init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  assign accept = req_valid && req_ready;
  assign rd_acc = accept && !req_write;
  assign wr_acc = accept && req_write;

  always_comb begin
    arr_we    = wr_acc;
    arr_addr  = addr;
    arr_wdata = wdata;
    arr_wstrb = wstrb;
    if (init_we) begin
      arr_we    = 1'b1;
      arr_addr  = init_cnt;
      arr_wdata = {NB{INIT_VAL}};
      arr_wstrb = '1;
    end
  end

  memory_bank_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .wstrb (arr_wstrb),
    .re    (rd_acc),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) rv1 <= 1'b0;
    else       rv1 <= rd_acc;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rv2;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rv2     <= 1'b0;
        rdata_q <= '0;
      end else begin
        rv2 <= rv1;
        if (rv1) rdata_q <= arr_rdata;
      end
    end

    assign rvalid = rv2;
    assign rdata  = rdata_q;
  end else begin : g_lat1
    // The array register has no reset, so rdata reads as zero until a read has completed.
    logic rd_seen;

    always_ff @(posedge clk) begin
      if (reset)    rd_seen <= 1'b0;
      else if (rv1) rd_seen <= 1'b1;
    end

    assign rvalid = rv1;
    assign rdata  = (rd_seen || rv1) ? arr_rdata : '0;
  end

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank: one instance at read latency 1 and one at 2, driven in lockstep.
module tb_memory_bank;

  localparam int AW = 2;
  localparam int DW = 16;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;

  logic          ready1, rvalid1, done1;
  logic [DW-1:0] rdata1;
  logic          ready2, rvalid2, done2;
  logic [DW-1:0] rdata2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .INIT_VAL(8'hFF)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid1), .rdata(rdata1), .init_done(done1)
  );

  memory_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .INIT_VAL(8'hFF)) dut_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2), .req_write(req_write),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid2), .rdata(rdata2), .init_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    while (!(done1 && done2) && cyc < 10) begin
      tick();
      cyc++;
    end
    check(tag, 32'(cyc), 32'd4);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    req_valid = 1'b1;
    req_write = 1'b1;
    addr      = a;
    wdata     = d;
    wstrb     = s;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = a;
    tick();
    req_valid = 1'b0;
    check({tag, " l1 rvalid"}, 32'(rvalid1), 32'd1);
    check({tag, " l1 rdata"}, 32'(rdata1), 32'(exp));
    check({tag, " l2 rvalid early"}, 32'(rvalid2), 32'd0);
    tick();
    check({tag, " l1 rvalid drop"}, 32'(rvalid1), 32'd0);
    check({tag, " l1 rdata hold"}, 32'(rdata1), 32'(exp));
    check({tag, " l2 rvalid"}, 32'(rvalid2), 32'd1);
    check({tag, " l2 rdata"}, 32'(rdata2), 32'(exp));
  endtask

  initial begin
    int stray;

    // Test 1: reset values, fill timing, filled contents
    tick();
    check("rst ready", 32'({ready1, ready2}), 32'd0);
    check("rst rvalid", 32'({rvalid1, rvalid2}), 32'd0);
    check("rst rdata l1", 32'(rdata1), 32'd0);
    check("rst rdata l2", 32'(rdata2), 32'd0);
    check("rst init_done", 32'({done1, done2}), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("init_done c%0d", i), 32'({done1, done2}), (i == 4) ? 32'd3 : 32'd0);
    end
    check("run ready", 32'({ready1, ready2}), 32'd3);
    for (int i = 0; i < 4; i++) read($sformatf("fill a%0d", i), AW'(i), 16'hFFFF);

    // Test 2: byte-lane strobes
    write(2'd1, 16'hA5C3, 2'b01);
    read("strb lo", 2'd1, 16'hFFC3);
    write(2'd1, 16'h1200, 2'b10);
    read("strb hi", 2'd1, 16'h12C3);
    write(2'd1, 16'h7777, 2'b00);
    read("strb none", 2'd1, 16'h12C3);

    // Test 4: write then immediate read of same address
    write(2'd3, 16'hBEEF, 2'b11);
    read("wr-rd", 2'd3, 16'hBEEF);

    // Test 3: back-to-back reads, both latencies
    for (int i = 0; i < 4; i++) write(AW'(i), DW'(i), 2'b11);
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 4) addr = AW'(k);
      else req_valid = 1'b0;
      check($sformatf("b2b l1 rvalid c%0d", k), 32'(rvalid1), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) check($sformatf("b2b l1 rdata c%0d", k), 32'(rdata1), 32'(k - 1));
      check($sformatf("b2b l2 rvalid c%0d", k), 32'(rvalid2), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) check($sformatf("b2b l2 rdata c%0d", k), 32'(rdata2), 32'(k - 2));
    end

    // Test 5: reset mid-fill, then reset with a read in flight
    pulse_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midfill done", 32'({done1, done2}), 32'd0);
    wait_init("refill cycles");
    write(2'd2, 16'h1234, 2'b11);
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = 2'd2;
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    check("flush rvalid", 32'({rvalid1, rvalid2}), 32'd0);
    check("flush rdata l1", 32'(rdata1), 32'd0);
    check("flush rdata l2", 32'(rdata2), 32'd0);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid1 || rvalid2) stray++;
    end
    check("no stray rvalid", 32'(stray), 32'd0);
    check("reinit done", 32'({done1, done2}), 32'd3);
    for (int i = 0; i < 4; i++) read($sformatf("refill a%0d", i), AW'(i), 16'hFFFF);

    // Test 6: request held through INIT is accepted exactly once
    pulse_reset();
    req_valid = 1'b1;
    req_write = 1'b1;
    addr      = 2'd0;
    wdata     = 16'h5A5A;
    wstrb     = 2'b11;
    begin
      int cyc = 0;
      while (!(ready1 && ready2) && cyc < 10) begin
        tick();
        cyc++;
      end
      check("held req wait", 32'(cyc), 32'd4);
    end
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    read("held a0", 2'd0, 16'h5A5A);
    read("held a1", 2'd1, 16'hFFFF);
    read("held a3", 2'd3, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
